// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage plus the IF/ID pipeline latch of the MIPS datapath.
// It owns the PC, drives the instruction-memory address combinationally from
// the PC, and registers the returned word together with PC+4 for decode.
//
// A two-state controller (BOOT/RUN) spends exactly one edge in BOOT after
// reset. No fetch happens on that edge, so the first real fetch of RESET_PC
// lands on the second edge.
//
// Ports
//   Clk         in   1  clock; all state updates on the rising edge
//   Rst         in   1  asynchronous active-high reset
//   Stall       in   1  hold PC and IF/ID (load-use hazard)
//   Redirect    in   1  taken branch / j / jal / jr resolved this cycle
//   RedirectPC  in  32  redirect target (low two bits ignored)
//   IMemAddr    out 32  instruction memory read address (= PC)
//   IMemData    in  32  instruction word at IMemAddr (combinational read)
//   Instruction out 32  IF/ID instruction register
//   PCPlus4     out 32  IF/ID: address of fetched instruction + 4
//   Valid       out  1  IF/ID holds a real instruction (0 = bubble)
//   FetchCount  out 32  number of instructions accepted into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        Valid,
  output logic [31:0] FetchCount
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q,  pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q,   cnt_d;

  // Sequential successor of the current PC. The addition is 32-bit modulo,
  // so 32'hFFFF_FFFC wraps to zero without any extra handling.
  logic [31:0] pc_inc;
  assign pc_inc = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Every register defaults to holding its value. That
  // default already covers BOOT (Stall and Redirect are ignored there) and
  // the stall case in RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (Redirect) begin
          // The word currently on IMemData belongs to the wrong path and is
          // dropped. A bubble goes into IF/ID instead. PCPlus4 is left alone
          // because decode ignores it while Valid is low.
          pc_d    = {RedirectPC[31:2], 2'b00};
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (!Stall) begin
          instr_d = IMemData;
          pcp4_d  = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          cnt_d   = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign IMemAddr    = pc_q;
  assign Instruction = instr_q;
  assign PCPlus4     = pcp4_q;
  assign Valid       = valid_q;
  assign FetchCount  = cnt_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the MIPS datapath. It sits directly upstream of the instruction decoder/controller. It holds the PC, drives the instruction-memory read address, and registers the fetched word and PC+4 into the IF/ID latch consumed by decode. It supports pipeline stalls from the hazard unit and redirects (taken branch, j, jal, jr) that flush the latch with a NOP bubble.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
- Clk  input  1  clock; all state updates on the rising edge
- Rst  input  1  asynchronous, active-high reset
- Stall  input  1  hold PC and IF/ID contents (load-use hazard)
- Redirect  input  1  taken branch/jump/jr resolved this cycle
- RedirectPC  input  32  target address for Redirect
- IMemAddr  output  32  instruction memory read address (= PC, combinational)
- IMemData  input  32  instruction word at IMemAddr, combinational read
- Instruction  output  32  IF/ID instruction register, feeds decode/controller
- PCPlus4  output  32  IF/ID register: address of fetched instruction + 4
- Valid  output  1  IF/ID holds a real fetched instruction (0 = bubble)
- FetchCount  output  32  count of instructions accepted into IF/ID

## Operation
- State machine with two states: BOOT and RUN.
  - Rst forces BOOT.
  - BOOT -> RUN on the first rising edge with Rst low. In BOOT the PC and IF/ID are held.
  - RUN persists until Rst.
- Reset values:
  - PC = RESET_PC
  - Instruction = NOP_WORD
  - PCPlus4 = 0
  - Valid = 0
  - FetchCount = 0
  - state = BOOT
- Priority each edge in RUN: Redirect > Stall > normal fetch.
- Normal fetch (RUN, Redirect=0, Stall=0):
  - Instruction <= IMemData
  - PCPlus4 <= PC+4
  - Valid <= 1
  - PC <= PC+4
  - FetchCount <= FetchCount+1
- Stall (RUN, Redirect=0, Stall=1): PC, Instruction, PCPlus4, Valid and FetchCount all hold.
- Redirect (RUN, Redirect=1, Stall is don't-care):
  - PC <= {RedirectPC[31:2], 2'b00}
  - Instruction <= NOP_WORD
  - Valid <= 0
  - PCPlus4 holds
  - FetchCount holds
  - The word currently at IMemData is discarded.
- Redirect or Stall asserted in BOOT: ignored; the BOOT -> RUN transition still occurs.
- Arithmetic:
  - PC+4 is 32-bit modulo; PC 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - FetchCount wraps from 32'hFFFF_FFFF to 0.
- PC[1:0] is always 2'b00. RESET_PC is used as given; it must be aligned.
- IMemAddr = PC at all times, including during reset.

## Timing
- Fetch latency:
  - The word addressed at edge N appears on Instruction after edge N+1.
  - One cycle from PC to IF/ID.
- After Rst deassertion:
  - Edge 1: BOOT -> RUN, no fetch.
  - Edge 2: first fetch of RESET_PC.
  - Instruction = mem[RESET_PC] and Valid = 1 after edge 2.
- Redirect penalty: exactly one bubble cycle.
  - Edge with Redirect: IF/ID becomes NOP and PC becomes the target.
  - Next edge: the target instruction enters IF/ID.
- Stall for k cycles holds outputs for k cycles; fetch resumes on the first edge with Stall=0.
- Rst asserted mid-operation: all registers take reset values immediately (asynchronous), regardless of Clk, Stall or Redirect.
- Redirect and Stall must be stable before the rising edge. They are sampled only at the edge; there are no combinational paths from them to outputs.

## Test plan
- Reset/boot:
  - Stimulus: Rst high 3 cycles, RESET_PC=0, mem[0]=32'h2008_0005, then release.
  - Required: IMemAddr=0 during reset; Valid=0 after edge 1; after edge 2, Instruction=32'h2008_0005, PCPlus4=4, Valid=1, FetchCount=1.
- Sequential fetch:
  - Stimulus: 5 free-running RUN edges.
  - Required: PC steps 0, 4, 8, 12, 16, 20; PCPlus4 tracks, always equal to fetched address+4; FetchCount=5.
- Stall:
  - Stimulus: Stall high 3 cycles at PC=8.
  - Required: PC=8 and Instruction/PCPlus4/FetchCount unchanged for 3 edges; mem[8] is captured on the first edge after Stall drops.
- Redirect with simultaneous stall:
  - Stimulus: at PC=12, Redirect=1, Stall=1, RedirectPC=32'h0000_0043.
  - Required: PC=32'h40, Instruction=NOP_WORD, Valid=0, FetchCount unchanged; next edge Instruction=mem[0x40], PCPlus4=32'h44.
- Wrap-around:
  - Stimulus: redirect to 32'hFFFF_FFFC, then one fetch.
  - Required: PCPlus4=0, PC=0.
- Async reset mid-stream:
  - Stimulus: pulse Rst between clock edges while at PC=32'h20.
  - Required: PC=RESET_PC, Valid=0, FetchCount=0 before the next edge, followed by the full BOOT sequence.
